// File: rtl/sfir_pkg.sv
// Shared types and helpers for the sample-rate FIR family: accumulator sizing,
// round-half-up plus saturate, and the MAC sequencer state encoding.
package sfir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } sfir_state_t;

    localparam int RS_W = 128;

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 1;
    endfunction

    // Adds half an LSB of the result before the arithmetic shift, then clamps
    // to the signed range of data_w bits.
    function automatic logic signed [63:0] round_sat(input logic signed [RS_W-1:0] x,
                                                     input int shift,
                                                     input int data_w);
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        r = x;
        if (shift > 0) begin
            r = (x + (128'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (data_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return 64'(r);
    endfunction

endpackage

// File: rtl/sfir_round_sat.sv
// Combinational round-and-saturate from an ACC_W accumulator to DATA_WIDTH.
// Zero latency; no flow control of its own.
module sfir_round_sat
    import sfir_pkg::*;
#(
    parameter int ACC_W      = 35,
    parameter int SHIFT      = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [ACC_W-1:0]      acc,
    output logic signed [DATA_WIDTH-1:0] dat
);

    if (ACC_W > RS_W) begin : g_acc_too_wide
        $error("sfir_round_sat: ACC_W exceeds helper width");
    end

    assign dat = DATA_WIDTH'(round_sat(RS_W'(acc), SHIFT, DATA_WIDTH));

endmodule

// File: rtl/sfir_polyphase_interp.sv
// Polyphase x INTERP interpolator on one shared MAC; first output PT+1 cycles after input accept.
// Accepts input only when idle; holds out_data_o/out_valid_o while out_ready_i is low.
module sfir_polyphase_interp
    import sfir_pkg::*;
#(
    parameter int INTERP            = 2,
    parameter int TAP_NUM           = 8,
    parameter int DATA_WIDTH        = 16,
    parameter int COEF_WIDTH        = 16,
    parameter int COEF [TAP_NUM]    = '{-1024, 0, 9216, 16384, 9216, 0, -1024, 0},
    parameter int SHIFT             = COEF_WIDTH - 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [DATA_WIDTH-1:0] in_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic signed [DATA_WIDTH-1:0] out_data_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i
);

    localparam int PT     = TAP_NUM / INTERP;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH, PT);
    localparam int PH_W   = (INTERP > 1) ? $clog2(INTERP) : 1;
    localparam int K_W    = (PT > 1) ? $clog2(PT) : 1;

    if (TAP_NUM % INTERP != 0) begin : g_bad_taps
        $error("sfir_polyphase_interp: TAP_NUM must be a multiple of INTERP");
    end

    for (genvar g = 0; g < TAP_NUM; g++) begin : g_coef_chk
        if ((longint'(COEF[g]) > (64'sd1 <<< (COEF_WIDTH - 1)) - 64'sd1) ||
            (longint'(COEF[g]) < -(64'sd1 <<< (COEF_WIDTH - 1)))) begin : g_bad_coef
            $error("sfir_polyphase_interp: COEF entry does not fit COEF_WIDTH");
        end
    end

    sfir_state_t                  state;
    sfir_state_t                  state_nxt;
    logic [PH_W-1:0]              phase;
    logic [K_W-1:0]               k;
    logic signed [DATA_WIDTH-1:0] dl [PT];
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_nxt;
    logic signed [COEF_WIDTH-1:0] coef_sel;
    logic signed [PROD_W-1:0]     prod;
    logic signed [DATA_WIDTH-1:0] rs_dat;
    logic                         last_tap;
    logic                         last_phase;

    assign last_tap   = (int'(k) == PT - 1);
    assign last_phase = (int'(phase) == INTERP - 1);
    assign in_ready_o = (state == IDLE);

    // Phase p uses the decimated tap set h[p], h[p+INTERP], h[p+2*INTERP], ...
    always_comb begin
        coef_sel = COEF_WIDTH'(COEF[int'(phase) + INTERP * int'(k)]);
        prod     = PROD_W'(dl[k]) * PROD_W'(coef_sel);
        acc_nxt  = acc + ACC_W'(prod);
    end

    sfir_round_sat #(
        .ACC_W      (ACC_W),
        .SHIFT      (SHIFT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_round_sat (
        .acc (acc_nxt),
        .dat (rs_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid_i) state_nxt = MAC;
            MAC:     if (last_tap) state_nxt = OUT;
            OUT:     if (out_ready_i) state_nxt = last_phase ? IDLE : MAC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < PT; j++) begin
                dl[j] <= '0;
            end
            acc         <= '0;
            phase       <= '0;
            k           <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        dl[0] <= in_data_i;
                        for (int j = 1; j < PT; j++) begin
                            dl[j] <= dl[j-1];
                        end
                        phase <= '0;
                        k     <= '0;
                        acc   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= k + K_W'(1);
                    if (last_tap) begin
                        out_data_o  <= rs_dat;
                        out_valid_o <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (!last_phase) begin
                            phase <= phase + PH_W'(1);
                            k     <= '0;
                            acc   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sfir_polyphase_interp.sv
// Randomised and directed checks of the polyphase interpolator against a direct-form
// convolution model; a second instance with full-scale taps exercises saturation.
module tb_sfir_polyphase_interp;

    localparam int INTERP = 2;
    localparam int TAPS   = 8;
    localparam int PT     = TAPS / INTERP;
    localparam int CA [TAPS] = '{-1024, 0, 9216, 16384, 9216, 0, -1024, 0};
    localparam int CB [TAPS] = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    localparam int IMP [10]  = '{-512, 0, 4608, 8192, 4608, 0, -512, 0, 0, 0};

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] in_data = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b1;
    logic               in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic signed [15:0] out_data_a, out_data_b;

    int     err_cnt = 0;
    int     chk_cnt = 0;
    int     hist[$];
    longint got_a[$];
    longint got_b[$];

    always #5 clk = ~clk;

    sfir_polyphase_interp u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_a),
        .out_data_o  (out_data_a),
        .out_valid_o (out_valid_a),
        .out_ready_i (out_ready)
    );

    sfir_polyphase_interp #(
        .COEF ('{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767})
    ) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_b),
        .out_data_o  (out_data_b),
        .out_valid_o (out_valid_b),
        .out_ready_i (out_ready)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Phase p of the interpolated output: sum_k x[n-k] * h[p + INTERP*k], rounded and clamped.
    function automatic longint model(input int p, input bit use_b);
        longint s = 0;
        for (int i = 0; i < PT; i++) begin
            if (i < hist.size()) begin
                s += longint'(hist[i]) * longint'(use_b ? CB[p + INTERP * i] : CA[p + INTERP * i]);
            end
        end
        s = (s + 64'sd16384) >>> 15;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic do_sample(input int x, input int stall);
        int     cyc;
        int     rdy_hi;
        int     bad;
        longint ea;
        longint eb;
        @(negedge clk);
        in_data   = 16'(x);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (!in_ready_a && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("in_ready", longint'(in_ready_a), 1);
        hist.push_front(x);
        for (int p = 0; p < INTERP; p++) begin
            cyc    = 0;
            rdy_hi = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                cyc++;
                if (in_ready_a || in_ready_b) rdy_hi++;
            end while (!out_valid_a && cyc < 50);
            chk("latency", cyc, PT + 1);
            chk("rdy_busy", rdy_hi, 0);
            ea = model(p, 1'b0);
            eb = model(p, 1'b1);
            chk("dat_a", longint'(out_data_a), ea);
            chk("dat_b", longint'(out_data_b), eb);
            chk("vld_b", longint'(out_valid_b), 1);
            got_a.push_back(longint'(out_data_a));
            got_b.push_back(longint'(out_data_b));
            if (stall > 0 && p == 0) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 16'($urandom);
                bad = 0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    if (!out_valid_a || longint'(out_data_a) != ea || in_ready_a) bad++;
                end
                chk("stall_hold", bad, 0);
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("rdy_back", longint'(in_ready_a && in_ready_b), 1);
    endtask

    task automatic mid_reset(input int x);
        int cyc;
        @(negedge clk);
        in_data   = 16'(x);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid_a && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_pre_vld", longint'(out_valid_a), 1);
        repeat (3) @(negedge clk);
        chk("rst_in_mac", longint'(out_valid_a), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_vld", longint'(out_valid_a || out_valid_b), 0);
        chk("rst_rdy", longint'(in_ready_a), 1);
        chk("rst_dat", longint'(out_data_a), 0);
        hist.delete();
    endtask

    task automatic check_impulse(input string tag);
        chk({tag, "_cnt"}, got_a.size(), 10);
        for (int i = 0; i < 10 && i < got_a.size(); i++) begin
            chk(tag, got_a[i], IMP[i]);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_vld", longint'(out_valid_a), 0);
        chk("rst_out_dat", longint'(out_data_a), 0);
        chk("rst_in_rdy", longint'(in_ready_a && in_ready_b), 1);

        got_a.delete();
        do_sample(16384, 0);
        for (int i = 0; i < 4; i++) do_sample(0, 0);
        check_impulse("impulse");

        got_a.delete();
        for (int i = 0; i < 8; i++) do_sample(1000, 0);
        for (int i = 6; i < 16; i++) chk("dc_1000", got_a[i], 500);

        got_a.delete();
        got_b.delete();
        for (int i = 0; i < 6; i++) do_sample(32767, 0);
        chk("dc_max_a", got_a[11], 16384);
        chk("sat_pos_b", got_b[11], 32767);
        chk("sat_pos_b1", got_b[10], 32767);

        got_b.delete();
        for (int i = 0; i < 6; i++) do_sample(-32768, 0);
        chk("sat_neg_b", got_b[11], -32768);
        chk("sat_neg_b1", got_b[10], -32768);

        do_sample(12345, 10);
        do_sample(-4321, 0);

        for (int i = 0; i < 24; i++) begin
            do_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)));
        end

        mid_reset(20000);
        got_a.delete();
        do_sample(16384, 0);
        for (int i = 0; i < 4; i++) do_sample(0, 0);
        check_impulse("impulse_post_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
